// File: rtl/alu_share_pkg.sv
// Shared definitions for the shared-ALU sequencer.
//   - sel_e   : ALU SELECT encodings as understood by the downstream ALU
//   - state_e : sequencer FSM states
//   - WIDTH_DEF : default operand/result width
package alu_share_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    SEL_FWD = 3'd0,
    SEL_ADD = 3'd1,
    SEL_AND = 3'd2,
    SEL_OR  = 3'd3,
    SEL_LSL = 3'd4,
    SEL_LSR = 3'd5,
    SEL_MUL = 3'd6,
    SEL_ILL = 3'd7   // no ALU case exists for this code
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_share_rr_arb.sv
// Two-way round-robin arbiter for the shared ALU.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : arbitration enabled (sequencer idle); no grant otherwise
//   req        : per-requester valid
//   gnt        : one-hot grant (combinational), zero when disabled
//   gnt_id     : index of the granted requester (meaningful when |gnt)
// The pointer remembers the last granted requester; it resets to 1 so that
// requester 0 wins the first contested round.
module alu_share_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic last_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (&req) gnt = last_q ? 2'b01 : 2'b10;
      else      gnt = req;
    end
  end

  assign gnt_id = gnt[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_q <= 1'b1;
    else if (|gnt) last_q <= gnt[1];
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Sequencer sharing one combinational ALU between two requesters
// (0: main datapath, 1: aux unit). One operation in flight at a time:
// IDLE accepts a request (round-robin), EXEC drives the latched operands to
// the ALU for the op's latency, RESP presents the captured result until the
// consumer takes it.
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   req_valid/req_ready [1:0]    : per-requester handshake (ready one-hot)
//   req0_a/b/sel, req1_a/b/sel   : requester payloads
//   alu_data1/data2/select       : to ALU (held from the last accepted op)
//   alu_result/alu_zero          : from ALU
//   rsp_valid/ready, rsp_id      : response handshake and owning requester
//   rsp_data/rsp_zero/rsp_err    : captured result, zero flag, illegal-op flag
// Build option ALU_SHARE_ILLEGAL_OP_EN: SELECT 7 bypasses the ALU and returns
// DATA=0, ZERO=1, ERR=1 one cycle after accept. Without it SELECT 7 runs as a
// normal BASE_LAT op and rsp_err stays 0.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int BASE_LAT = 1,
  parameter int MULT_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_sel,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_sel,
  output logic [WIDTH-1:0] alu_data1,
  output logic [WIDTH-1:0] alu_data2,
  output logic [2:0]       alu_select,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err
);

`ifdef ALU_SHARE_ILLEGAL_OP_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  localparam int MAX_LAT = (BASE_LAT > MULT_LAT) ? BASE_LAT : MULT_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  state_e             state_q, state_d;
  logic [1:0]         gnt;
  logic               gnt_id;
  logic               xfer;
  logic               ill_acc;
  logic [WIDTH-1:0]   in_a, in_b;
  logic [2:0]         in_sel;
  logic [CNT_W-1:0]   lat_load;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2:0]         sel_q;
  logic               id_q;
  logic [WIDTH-1:0]   data_q;
  logic               zero_q;
  logic               err_q;

  alu_share_rr_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state_q == ST_IDLE),
    .req    (req_valid),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign in_a      = gnt_id ? req1_a   : req0_a;
  assign in_b      = gnt_id ? req1_b   : req0_b;
  assign in_sel    = gnt_id ? req1_sel : req0_sel;
  assign ill_acc   = ILL_EN && (in_sel == SEL_ILL);
  assign lat_load  = (in_sel == SEL_MUL) ? CNT_W'(MULT_LAT) : CNT_W'(BASE_LAT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (xfer) state_d = ill_acc ? ST_RESP : ST_EXEC;
      ST_EXEC: if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Operand, counter and response registers. All are cleared by reset
  // because the ALU and response outputs must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sel_q  <= '0;
      id_q   <= 1'b0;
      cnt_q  <= '0;
      data_q <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            id_q <= gnt_id;
            if (ill_acc) begin
              // Illegal op never reaches the ALU; ALU outputs keep old values.
              data_q <= '0;
              zero_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              a_q   <= in_a;
              b_q   <= in_b;
              sel_q <= in_sel;
              cnt_q <= lat_load;
            end
          end
        end
        ST_EXEC: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            data_q <= alu_result;
            zero_q <= alu_zero;
            err_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_data1  = a_q;
  assign alu_data2  = b_q;
  assign alu_select = sel_q;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = id_q;
  assign rsp_data   = data_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;

  localparam int W  = 8;
  localparam int BL = 1;
  localparam int ML = 2;

`ifdef ALU_SHARE_ILLEGAL_OP_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid, req_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_sel, req1_sel;
  logic [W-1:0] alu_data1, alu_data2, alu_result;
  logic [2:0]   alu_select;
  logic         alu_zero;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [W-1:0] rsp_data;
  logic [15:0]  prod;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: last granted requester and values expected on ALU_*.
  int           last_gnt;
  logic [W-1:0] m_a, m_b;
  logic [2:0]   m_sel;

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(W), .BASE_LAT(BL), .MULT_LAT(ML)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_select(alu_select),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  // Stand-in ALU. SELECT 7 has no case; it returns a fixed junk value.
  assign prod = alu_data1 * alu_data2;
  always_comb begin
    alu_result = 8'hA5;
    case (alu_select)
      3'd0: alu_result = alu_data1;
      3'd1: alu_result = alu_data1 + alu_data2;
      3'd2: alu_result = alu_data1 & alu_data2;
      3'd3: alu_result = alu_data1 | alu_data2;
      3'd4: alu_result = alu_data1 << alu_data2[2:0];
      3'd5: alu_result = alu_data1 >> alu_data2[2:0];
      3'd6: alu_result = prod[7:0];
      default: alu_result = 8'hA5;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  function automatic logic [W-1:0] ref_op(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    int r;
    case (s)
      3'd0: r = a;
      3'd1: r = a + b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a * (2 ** b[2:0]);
      3'd5: r = a / (2 ** b[2:0]);
      3'd6: r = a * b;
      default: r = 'hA5;
    endcase
    return r[W-1:0];
  endfunction

  function automatic int pred_gnt(input logic [1:0] vm);
    if (vm == 2'b11) return 1 - last_gnt;
    return vm[1] ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Present vm on req_valid (caller at negedge+1, payload already set),
  // check grant, follow the op through to the response handshake.
  task automatic run_txn(input logic [1:0] vm, input logic [W-1:0] ed, input logic ez,
                         input logic ee, input int lat, input int hold);
    int g, k;
    logic [2:0] s;
    g = pred_gnt(vm);
    req_valid = vm;
    #1;
    chk("grant", {30'd0, req_ready}, 32'(2'b01 << g));
    s = g ? req1_sel : req0_sel;
    if (!(ILL_EN && s == 3'd7)) begin
      m_a = g ? req1_a : req0_a;
      m_b = g ? req1_b : req0_b;
      m_sel = s;
    end
    last_gnt = g;
    @(negedge clk); #1;
    req_valid[g] = 1'b0;
    k = 1;
    while (!rsp_valid && k <= 20) begin
      chk("busy_ready", {30'd0, req_ready}, 32'd0);
      chk("alu_stable", {13'd0, alu_select, alu_data2, alu_data1}, {13'd0, m_sel, m_b, m_a});
      @(negedge clk); #1;
      k++;
    end
    chk("latency", k, lat);
    for (int h = 0; h < hold; h++) begin
      chk("hold_data", {22'd0, rsp_err, rsp_zero, rsp_data}, {22'd0, ee, ez, ed});
      chk("hold_ready", {29'd0, rsp_valid, req_ready}, {29'd0, 1'b1, 2'b00});
      @(negedge clk); #1;
    end
    chk("rsp_data", rsp_data, ed);
    chk("rsp_flags", {29'd0, rsp_err, rsp_zero, rsp_id}, {29'd0, ee, ez, g[0]});
    chk("alu_final", {13'd0, alu_select, alu_data2, alu_data1}, {13'd0, m_sel, m_b, m_a});
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_drop", {31'd0, rsp_valid}, 32'd0);
  endtask

  typedef struct {
    logic       rq;
    logic [2:0] sel;
    logic [W-1:0] a, b, ed;
    logic       ez, ee;
    int         lat, hold;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b0, 3'd1, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 2, 0};
    vecs[1]  = '{1'b0, 3'd6, 8'h04, 8'h03, 8'h0C, 1'b0, 1'b0, 3, 0};
    vecs[2]  = '{1'b1, 3'd2, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 2, 0};
    vecs[3]  = '{1'b1, 3'd3, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 2, 5};
    vecs[4]  = '{1'b0, 3'd4, 8'h81, 8'h01, 8'h02, 1'b0, 1'b0, 2, 0};
    vecs[5]  = '{1'b1, 3'd5, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 2, 0};
    vecs[6]  = '{1'b0, 3'd1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 2, 0};
    vecs[7]  = '{1'b1, 3'd6, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 3, 0};
    vecs[8]  = '{1'b0, 3'd0, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0, 2, 0};
`ifdef ALU_SHARE_ILLEGAL_OP_EN
    vecs[9]  = '{1'b0, 3'd7, 8'h12, 8'h34, 8'h00, 1'b1, 1'b1, 1, 2};
`else
    vecs[9]  = '{1'b0, 3'd7, 8'h12, 8'h34, 8'hA5, 1'b0, 1'b0, 2, 2};
`endif
    vecs[10] = '{1'b1, 3'd1, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 2, 0};

    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_sel = '0;
    req1_a = '0; req1_b = '0; req1_sel = '0;
    last_gnt = 1; m_a = '0; m_b = '0; m_sel = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctrl", {29'd0, rsp_valid, req_ready}, 32'd0);
    chk("reset_alu", {13'd0, alu_select, alu_data2, alu_data1}, 32'd0);
    chk("reset_rsp", {21'd0, rsp_err, rsp_zero, rsp_id, rsp_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Both valid after reset: req0 first, then req1, then req0 again.
    req0_a = 8'h00; req0_b = 8'h00; req0_sel = 3'd0;
    req1_a = 8'hF0; req1_b = 8'h0F; req1_sel = 3'd3;
    run_txn(2'b11, 8'h00, 1'b1, 1'b0, 2, 0);
    run_txn(2'b10, 8'hFF, 1'b0, 1'b0, 2, 0);
    run_txn(2'b11, 8'h00, 1'b1, 1'b0, 2, 0);
    run_txn(2'b10, 8'hFF, 1'b0, 1'b0, 2, 0);

    // Table of single-requester vectors.
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].rq) begin
        req1_a = vecs[i].a; req1_b = vecs[i].b; req1_sel = vecs[i].sel;
      end else begin
        req0_a = vecs[i].a; req0_b = vecs[i].b; req0_sel = vecs[i].sel;
      end
      run_txn(vecs[i].rq ? 2'b10 : 2'b01, vecs[i].ed, vecs[i].ez, vecs[i].ee,
              vecs[i].lat, vecs[i].hold);
    end

    // Reset asserted during EXEC discards the op.
    req0_a = 8'h05; req0_b = 8'h03; req0_sel = 3'd6;
    req_valid = 2'b01;
    @(negedge clk); #1;
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {29'd0, rsp_valid, req_ready}, 32'd0);
    chk("midrst_alu", {13'd0, alu_select, alu_data2, alu_data1}, 32'd0);
    chk("midrst_rsp", {21'd0, rsp_err, rsp_zero, rsp_id, rsp_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_gnt = 1; m_a = '0; m_b = '0; m_sel = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("midrst_norsp", {31'd0, rsp_valid}, 32'd0);
    end
    req0_a = 8'h05; req0_b = 8'h03; req0_sel = 3'd1;
    req1_a = 8'h01; req1_b = 8'h01; req1_sel = 3'd1;
    run_txn(2'b11, 8'h08, 1'b0, 1'b0, 2, 0);
    run_txn(2'b10, 8'h02, 1'b0, 1'b0, 2, 0);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 150; t++) begin
      logic [1:0]   nw, vm;
      logic [2:0]   s;
      logic [W-1:0] a, b, ed;
      int           g, lat;
      bit           ill;
      nw = 2'($urandom_range(0, 3));
      if ((req_valid | nw) == 2'b00) nw = 2'($urandom_range(1, 3));
      if (nw[0] && !req_valid[0]) begin
        req0_a = 8'($urandom); req0_b = 8'($urandom); req0_sel = 3'($urandom);
      end
      if (nw[1] && !req_valid[1]) begin
        req1_a = 8'($urandom); req1_b = 8'($urandom); req1_sel = 3'($urandom);
      end
      vm = req_valid | nw;
      g = pred_gnt(vm);
      s = g ? req1_sel : req0_sel;
      a = g ? req1_a : req0_a;
      b = g ? req1_b : req0_b;
      ill = ILL_EN && (s == 3'd7);
      ed = ill ? 8'h00 : ref_op(s, a, b);
      lat = ill ? 1 : ((s == 3'd6) ? ML : BL) + 1;
      run_txn(vm, ed, (ed == 8'h00), ill, lat, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
